// File: rtl/vb_pix_bridge.sv
// VerilogBoy pixel stream to dsi_core RGB888 bridge: ping-pong line buffers, palette, integer upscale.
// Optional macro VB_PIX_PALETTE_WR_EN adds a writable 16-entry palette (pal_we/pal_idx/pal_rgb).
module vb_pix_bridge #(
    parameter int H_ACTIVE = 160,
    parameter int SCALE    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  vb_pixel,
    input  logic        vb_valid,
    input  logic        vb_hs,
    input  logic        vb_vs,
    input  logic        pix_almost_full,
    input  logic        pix_next_frame,
`ifdef VB_PIX_PALETTE_WR_EN
    input  logic        pal_we,
    input  logic [3:0]  pal_idx,
    input  logic [23:0] pal_rgb,
`endif
    output logic [23:0] pix,
    output logic        pix_wr,
    output logic        pix_vsync,
    output logic        overflow
);

    localparam logic [7:0] X_LAST = 8'(H_ACTIVE - 1);
    localparam logic [1:0] S_LAST = 2'(SCALE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAITF, ST_EMIT} state_t;

    function automatic logic [23:0] f_default_rgb(input logic [1:0] code);
        case (code)
            2'd0:    return 24'hE0F8D0;
            2'd1:    return 24'h88C070;
            2'd2:    return 24'h346856;
            default: return 24'h081820;
        endcase
    endfunction

    // Both line buffers share one array; the buffer select is the address MSB.
    logic [3:0]  r_mem [512];
    logic [3:0]  r_rd_data;

    logic        r_vs_d;
    logic [7:0]  r_wx;
    logic        r_wsel;
    logic        r_rsel;
    logic [1:0]  r_full;
    logic [1:0]  r_sof;
    logic        r_sof_pend;
    logic        r_overflow;

    logic        w_vs_rise;
    logic [7:0]  w_wx_eff;
    logic        w_wr_en;
    logic        w_wr_last;

    state_t      r_state, w_state_next;
    logic [7:0]  r_ox, w_ox_next;
    logic [1:0]  r_hx, w_hx_next;
    logic [1:0]  r_rep, w_rep_next;
    logic        w_rsel_next;
    logic        w_issue;
    logic        w_rd_done;
    logic        w_vsync_next;

    logic        r_rd_vld;
    logic [23:0] r_pix;
    logic        r_pix_wr;
    logic        r_pix_vsync;
    logic [23:0] w_pal_rgb;
    logic        w_unused;

    assign w_vs_rise = vb_vs & ~r_vs_d;
    assign w_wx_eff  = w_vs_rise ? 8'd0 : r_wx;
    assign w_wr_en   = vb_valid & ~r_full[r_wsel];
    assign w_wr_last = w_wr_en & (w_wx_eff == X_LAST);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{r_wsel, w_wx_eff}] <= vb_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_rd_data <= r_mem[{r_rsel, r_ox}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_d     <= 1'b0;
            r_wx       <= 8'd0;
            r_wsel     <= 1'b0;
            r_full     <= 2'b00;
            r_sof      <= 2'b00;
            r_sof_pend <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_vs_d <= vb_vs;
            r_wx   <= w_wx_eff;
            if (w_vs_rise) begin
                r_sof_pend <= 1'b1;
            end
            if (w_wr_en) begin
                if (w_wr_last) begin
                    r_full[r_wsel] <= 1'b1;
                    r_sof[r_wsel]  <= r_sof_pend | w_vs_rise;
                    r_sof_pend     <= 1'b0;
                    r_wsel         <= ~r_wsel;
                    r_wx           <= 8'd0;
                end else begin
                    r_wx <= w_wx_eff + 8'd1;
                end
            end
            if (vb_valid && r_full[r_wsel]) begin
                r_overflow <= 1'b1;
            end
            // Never the buffer being filled: wsel differs from rsel while rsel is full.
            if (w_rd_done) begin
                r_full[r_rsel] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ox    <= 8'd0;
            r_hx    <= 2'd0;
            r_rep   <= 2'd0;
            r_rsel  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ox    <= w_ox_next;
            r_hx    <= w_hx_next;
            r_rep   <= w_rep_next;
            r_rsel  <= w_rsel_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ox_next    = r_ox;
        w_hx_next    = r_hx;
        w_rep_next   = r_rep;
        w_rsel_next  = r_rsel;
        w_issue      = 1'b0;
        w_rd_done    = 1'b0;
        w_vsync_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_full[r_rsel]) begin
                    w_ox_next    = 8'd0;
                    w_hx_next    = 2'd0;
                    w_rep_next   = 2'd0;
                    w_state_next = r_sof[r_rsel] ? ST_WAITF : ST_EMIT;
                end
            end
            ST_WAITF: begin
                if (pix_next_frame) begin
                    w_vsync_next = 1'b1;
                    w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (!pix_almost_full) begin
                    w_issue = 1'b1;
                    if (r_hx == S_LAST) begin
                        w_hx_next = 2'd0;
                        if (r_ox == X_LAST) begin
                            w_ox_next = 8'd0;
                            if (r_rep == S_LAST) begin
                                w_rep_next   = 2'd0;
                                w_rd_done    = 1'b1;
                                w_rsel_next  = ~r_rsel;
                                w_state_next = ST_IDLE;
                            end else begin
                                w_rep_next = r_rep + 2'd1;
                            end
                        end else begin
                            w_ox_next = r_ox + 8'd1;
                        end
                    end else begin
                        w_hx_next = r_hx + 2'd1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

`ifdef VB_PIX_PALETTE_WR_EN
    logic [23:0] r_pal [16];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_pal[i] <= f_default_rgb(i[1:0]);
            end
        end else if (pal_we) begin
            r_pal[pal_idx] <= pal_rgb;
        end
    end

    assign w_pal_rgb = r_pal[r_rd_data];
    assign w_unused  = vb_hs;
`else
    assign w_pal_rgb = f_default_rgb(r_rd_data[1:0]);
    assign w_unused  = ^{vb_hs, r_rd_data[3:2]};
`endif

    // Stage 1 is the buffer read above; stage 2 registers the palette result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld    <= 1'b0;
            r_pix       <= 24'd0;
            r_pix_wr    <= 1'b0;
            r_pix_vsync <= 1'b0;
        end else begin
            r_rd_vld    <= w_issue;
            r_pix_wr    <= r_rd_vld;
            r_pix_vsync <= w_vsync_next;
            if (r_rd_vld) begin
                r_pix <= w_pal_rgb;
            end
        end
    end

    assign pix       = r_pix;
    assign pix_wr    = r_pix_wr;
    assign pix_vsync = r_pix_vsync;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_vb_pix_bridge.sv
// Scoreboard bench for vb_pix_bridge: expected pixels queued per driven line, popped on pix_wr.
module tb_vb_pix_bridge;

    localparam int H = 160;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  vb_pixel;
    logic        vb_valid;
    logic        vb_hs;
    logic        vb_vs;
    logic        pix_almost_full;
    logic        pix_next_frame;
    logic [23:0] pix;
    logic        pix_wr;
    logic        pix_vsync;
    logic        overflow;
`ifdef VB_PIX_PALETTE_WR_EN
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [23:0] pal_rgb;
`endif

    always #5 clk = ~clk;

    vb_pix_bridge #(.H_ACTIVE(H), .SCALE(S)) dut (
        .clk             (clk),
        .rst             (rst),
        .vb_pixel        (vb_pixel),
        .vb_valid        (vb_valid),
        .vb_hs           (vb_hs),
        .vb_vs           (vb_vs),
        .pix_almost_full (pix_almost_full),
        .pix_next_frame  (pix_next_frame),
`ifdef VB_PIX_PALETTE_WR_EN
        .pal_we          (pal_we),
        .pal_idx         (pal_idx),
        .pal_rgb         (pal_rgb),
`endif
        .pix             (pix),
        .pix_wr          (pix_wr),
        .pix_vsync       (pix_vsync),
        .overflow        (overflow)
    );

    int          total = 0;
    int          bad   = 0;
    int          wr_cnt = 0;
    int          vs_cnt = 0;
    logic        vs_prev = 1'b0;
    logic [23:0] sb_q [$];
    logic [3:0]  line_buf [H];
    logic [23:0] pal_model [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input logic [3:0] c);
        return pal_model[c];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (pix_vsync) begin
                vs_cnt++;
                chk("vsync_1cyc", {31'd0, vs_prev}, 0);
            end
            if (pix_wr) begin
                wr_cnt++;
                if (sb_q.size() == 0) begin
                    chk("spurious_wr", {31'd0, pix_wr}, 0);
                end else begin
                    chk("pix", {8'd0, pix}, {8'd0, sb_q.pop_front()});
                end
            end
        end
        vs_prev = pix_vsync & ~rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        vb_vs = 1'b1;
        step();
        vb_vs = 1'b0;
        step();
    endtask

    task automatic drive_line(input bit keep, input string name);
        if (keep) begin
            for (int r = 0; r < S; r++)
                for (int x = 0; x < H; x++)
                    for (int h = 0; h < S; h++)
                        sb_q.push_back(exp_rgb(line_buf[x]));
        end
        for (int x = 0; x < H; x++) begin
            vb_valid = 1'b1;
            vb_pixel = line_buf[x];
            step();
        end
        vb_valid = 1'b0;
        $display("line %s driven keep=%0d first=%0d queued=%0d", name, keep, line_buf[0], sb_q.size());
    endtask

    task automatic fill_random();
        for (int x = 0; x < H; x++) line_buf[x] = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 5000) begin
            step();
            n++;
        end
        chk("drain", sb_q.size(), 0);
        repeat (10) step();
    endtask

    task automatic wait_wr(input int target);
        int n = 0;
        while (wr_cnt < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (wr_cnt < target) chk("wait_wr", wr_cnt, target);
    endtask

    initial begin
        int w0, v0, wa;
        pal_model[0] = 24'hE0F8D0;
        pal_model[1] = 24'h88C070;
        pal_model[2] = 24'h346856;
        pal_model[3] = 24'h081820;
        for (int i = 4; i < 16; i++) pal_model[i] = pal_model[i % 4];

        rst = 1'b1; vb_pixel = 4'd0; vb_valid = 1'b0; vb_hs = 1'b0; vb_vs = 1'b0;
        pix_almost_full = 1'b0; pix_next_frame = 1'b0;
`ifdef VB_PIX_PALETTE_WR_EN
        pal_we = 1'b0; pal_idx = 4'd0; pal_rgb = 24'd0;
`endif
        repeat (3) step();
        rst = 1'b0;
        chk("rst_pix", {8'd0, pix}, 0);
        chk("rst_wr", {31'd0, pix_wr}, 0);
        chk("rst_vsync", {31'd0, pix_vsync}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);

        // Frame start with a solid code-1 line.
        pix_next_frame = 1'b1;
        w0 = wr_cnt; v0 = vs_cnt;
        vs_pulse();
        for (int x = 0; x < H; x++) line_buf[x] = 4'd1;
        drive_line(1, "solid1");
        wait_drain();
        chk("t1_vsync", vs_cnt - v0, 1);
        chk("t1_wr", wr_cnt - w0, H * S * S);

        // Repeating 0..3 pattern, then a line led by code 7.
        w0 = wr_cnt; v0 = vs_cnt;
        for (int x = 0; x < H; x++) line_buf[x] = 4'(x % 4);
        drive_line(1, "ramp");
        fill_random();
        line_buf[0] = 4'd7; line_buf[1] = 4'd7;
        drive_line(1, "code7");
        wait_drain();
        chk("t2_wr", wr_cnt - w0, 2 * H * S * S);
        chk("t2_no_vsync", vs_cnt - v0, 0);

        // Backpressure in the middle of a line.
        w0 = wr_cnt;
        fill_random();
        drive_line(1, "backpressure");
        wait_wr(w0 + 100);
        #1;
        pix_almost_full = 1'b1;
        wa = wr_cnt;
        repeat (50) step();
        chk("af_extra_le2", {31'd0, (wr_cnt - wa) <= 2}, 1);
        pix_almost_full = 1'b0;
        wait_drain();
        chk("t3_wr", wr_cnt - w0, H * S * S);

        // Held frame start: two lines buffered, third dropped.
        pix_next_frame = 1'b0;
        w0 = wr_cnt; v0 = vs_cnt;
        vs_pulse();
        fill_random();
        drive_line(1, "held1");
        fill_random();
        drive_line(1, "held2");
        fill_random();
        drive_line(0, "dropped3");
        repeat (5) step();
        chk("ovf_set", {31'd0, overflow}, 1);
        chk("t4_no_wr_held", wr_cnt - w0, 0);
        pix_next_frame = 1'b1;
        wait_drain();
        chk("t4_vsync", vs_cnt - v0, 1);
        chk("t4_wr", wr_cnt - w0, 2 * H * S * S);
        chk("ovf_sticky", {31'd0, overflow}, 1);

        // Reset in the middle of emission.
        vs_pulse();
        w0 = wr_cnt;
        fill_random();
        drive_line(1, "interrupted");
        wait_wr(w0 + 50);
        #1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_q.delete();
        chk("midrst_wr", {31'd0, pix_wr}, 0);
        chk("midrst_ovf", {31'd0, overflow}, 0);
        w0 = wr_cnt;
        repeat (20) step();
        chk("midrst_quiet", wr_cnt - w0, 0);
        w0 = wr_cnt; v0 = vs_cnt;
        vs_pulse();
        fill_random();
        drive_line(1, "after_rst");
        wait_drain();
        chk("t5_vsync", vs_cnt - v0, 1);
        chk("t5_wr", wr_cnt - w0, H * S * S);

`ifdef VB_PIX_PALETTE_WR_EN
        pal_we = 1'b1; pal_idx = 4'd2; pal_rgb = 24'h123456;
        step();
        pal_we = 1'b0;
        pal_model[2] = 24'h123456;
        w0 = wr_cnt;
        for (int x = 0; x < H; x++) line_buf[x] = (x % 8 == 0) ? 4'd6 : 4'd2;
        drive_line(1, "palwr");
        wait_drain();
        chk("t6_wr", wr_cnt - w0, H * S * S);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
